// File: rtl/path_replayer_if.sv
// Stack-side and downstream move channels of the path replayer.
// master = replayer side, slave = stack/consumer side.
interface path_replayer_if;
   logic [1:0] stk_data;
   logic       stk_empty;
   logic       stk_pop;
   logic       out_ready;
   logic       out_valid;
   logic [1:0] out_dir;
   logic [3:0] out_move;

   modport master (
      input  stk_data, stk_empty, out_ready,
      output stk_pop, out_valid, out_dir, out_move
   );

   modport slave (
      output stk_data, stk_empty, out_ready,
      input  stk_pop, out_valid, out_dir, out_move
   );
endinterface

// File: rtl/path_replayer.sv
// Drains the direction stack top-to-bottom, emitting one (optionally reversed)
// move per handshake with a settle delay before every stack sample.
module path_replayer #(
   parameter int SETTLE_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 reverse,
   input  logic                 abort,
   path_replayer_if.master      bus,
   output logic                 busy,
   output logic                 done,
   output logic [8:0]           count
);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CHECK,
      EMIT,
      POP,
      FIN
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   state_t     state_reg;
   logic [3:0] settle_reg;
   logic       reverse_reg;
   logic       valid_reg;
   logic [1:0] dir_reg;
   logic [3:0] move_reg;
   logic       pop_reg;
   logic       busy_reg;
   logic       done_reg;
   logic [8:0] count_reg;
   logic [1:0] check_dir;

   // Reversal flips the vertical/horizontal sense bit: up<->down, right<->left.
   assign check_dir = bus.stk_data ^ {reverse_reg, 1'b0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         settle_reg  <= '0;
         reverse_reg <= 1'b0;
         valid_reg   <= 1'b0;
         dir_reg     <= 2'b00;
         move_reg    <= 4'b0000;
         pop_reg     <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         count_reg   <= '0;
      end else begin
         pop_reg  <= 1'b0;
         done_reg <= 1'b0;
         if (abort && state_reg != IDLE) begin
            // Abort beats a same-cycle handshake, so no pop escapes.
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            move_reg  <= 4'b0000;
            busy_reg  <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start && !abort) begin
                     reverse_reg <= reverse;
                     count_reg   <= '0;
                     settle_reg  <= SETTLE_LOAD;
                     busy_reg    <= 1'b1;
                     state_reg   <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (settle_reg == 4'd0) begin
                     state_reg <= CHECK;
                  end else begin
                     settle_reg <= settle_reg - 4'd1;
                  end
               end
               CHECK: begin
                  if (bus.stk_empty) begin
                     done_reg  <= 1'b1;
                     state_reg <= FIN;
                  end else begin
                     dir_reg   <= check_dir;
                     move_reg  <= 4'b0001 << check_dir;
                     valid_reg <= 1'b1;
                     state_reg <= EMIT;
                  end
               end
               EMIT: begin
                  if (bus.out_ready) begin
                     valid_reg <= 1'b0;
                     move_reg  <= 4'b0000;
                     pop_reg   <= 1'b1;
                     if (count_reg != 9'd511) begin
                        count_reg <= count_reg + 9'd1;
                     end
                     state_reg <= POP;
                  end
               end
               POP: begin
                  settle_reg <= SETTLE_LOAD;
                  state_reg  <= SETTLE;
               end
               FIN: begin
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
               default: begin
                  busy_reg  <= 1'b0;
                  valid_reg <= 1'b0;
                  move_reg  <= 4'b0000;
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.stk_pop   = pop_reg;
   assign bus.out_valid = valid_reg;
   assign bus.out_dir   = dir_reg;
   assign bus.out_move  = move_reg;
   assign busy          = busy_reg;
   assign done          = done_reg;
   assign count         = count_reg;

endmodule

// File: tb/tb_path_replayer.sv
// Randomized bench for path_replayer: a queue models the direction stack and
// expected moves/timing are derived from the stack contents and SETTLE_CYC.
module tb_path_replayer;
   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       reverse = 1'b0;
   logic       abort = 1'b0;
   logic       busy;
   logic       done;
   logic [8:0] count;

   path_replayer_if bus ();

   path_replayer #(.SETTLE_CYC(S)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .reverse (reverse),
      .abort   (abort),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .count   (count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int stk[$];
   int pop_total = 0;
   int pop_empty_err = 0;
   logic [3:0] onehot [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   task automatic refresh_stack();
      bus.stk_empty = (stk.size() == 0);
      bus.stk_data  = (stk.size() > 0) ? 2'(stk[stk.size()-1]) : 2'b00;
   endtask

   // Stack model: a pop strobe seen at a clock edge removes the top entry.
   always @(posedge clk) begin
      if (bus.stk_pop === 1'b1) begin
         pop_total++;
         if (stk.size() == 0) pop_empty_err++;
         else void'(stk.pop_back());
      end
      refresh_stack();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_stack(input int n);
      stk.delete();
      for (int i = 0; i < n; i++) stk.push_back(int'($urandom_range(0, 3)));
      refresh_stack();
   endtask

   task automatic test_reset();
      fill_stack(3);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start = 1'($urandom); reverse = 1'($urandom); abort = 1'($urandom);
         bus.out_ready = 1'($urandom);
         tick();
         tests++;
         if ({busy, done, count, bus.stk_pop, bus.out_valid, bus.out_dir, bus.out_move} !== '0) begin
            fails++;
            $display("FAIL reset_hold: outputs busy=%b done=%b count=%0d pop=%b valid=%b dir=%b move=%b, need all 0",
                     busy, done, count, bus.stk_pop, bus.out_valid, bus.out_dir, bus.out_move);
         end
      end
      start = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         abort = 1'($urandom); reverse = 1'($urandom); bus.out_ready = 1'($urandom);
         tick();
         tests++;
         if ({busy, done, count, bus.stk_pop, bus.out_valid, bus.out_move} !== '0) begin
            fails++;
            $display("FAIL reset_release: busy=%b done=%b count=%0d pop=%b valid=%b move=%b, need all 0",
                     busy, done, count, bus.stk_pop, bus.out_valid, bus.out_move);
         end
      end
      abort = 1'b0;
      $display("[TB] reset: held 5 cycles, released 4 cycles idle");
   endtask

   // Drains whatever the stack model currently holds, with out_ready tied high.
   task automatic test_drain(input string name, input bit rev);
      int exp_q[$];
      int n, idx, done_edge, pops0, exp_done;
      logic prev_v;
      n = stk.size();
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(stk[i] ^ (rev ? 2 : 0));
      pops0 = pop_total; idx = 0; done_edge = -1; prev_v = 1'b0;
      exp_done = S + 2 + n * (S + 3);
      reverse = rev; bus.out_ready = 1'b1; start = 1'b1;
      for (int e = 1; e <= exp_done + 6; e++) begin
         tick();
         start = 1'b0;
         reverse = 1'($urandom);
         if (bus.out_valid === 1'b1 && !prev_v) begin
            if (idx >= n) begin
               tests++; fails++;
               $display("FAIL %s extra_move: dir %b at edge %0d, need no move", name, bus.out_dir, e);
            end else begin
               tests++;
               if (e != S + 2 + idx * (S + 3)) begin
                  fails++;
                  $display("FAIL %s move%0d_timing: edge %0d, need %0d", name, idx, e, S + 2 + idx * (S + 3));
               end
               tests++;
               if (bus.out_dir !== 2'(exp_q[idx]) || bus.out_move !== onehot[exp_q[idx]]) begin
                  fails++;
                  $display("FAIL %s move%0d_value: dir %b move %b, need dir %b move %b", name, idx,
                           bus.out_dir, bus.out_move, 2'(exp_q[idx]), onehot[exp_q[idx]]);
               end
               idx++;
            end
         end
         prev_v = bus.out_valid;
         if (done === 1'b1) begin
            done_edge = e;
            break;
         end
      end
      tests++;
      if (done_edge != exp_done || idx != n) begin
         fails++;
         $display("FAIL %s done_timing: done edge %0d moves %0d, need edge %0d moves %0d", name, done_edge, idx, exp_done, n);
      end
      tests++;
      if (count !== 9'(n) || pop_total - pops0 != n) begin
         fails++;
         $display("FAIL %s totals: count %0d pops %0d, need %0d", name, count, pop_total - pops0, n);
      end
      tick();
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 9'(n)) begin
         fails++;
         $display("FAIL %s after_done: done %b busy %b count %0d, need 0 0 %0d", name, done, busy, count, n);
      end
      $display("[TB] %s: rev=%0b entries=%0d moves=%0d done@%0d count=%0d", name, rev, n, idx, done_edge, count);
   endtask

   task automatic test_fixed_stacks();
      stk.delete(); stk.push_back(0); stk.push_back(1); stk.push_back(3); refresh_stack();
      test_drain("fixed_fwd", 1'b0);
      stk.delete(); stk.push_back(0); stk.push_back(1); stk.push_back(3); refresh_stack();
      test_drain("fixed_rev", 1'b1);
   endtask

   task automatic test_backpressure();
      int pops0, bound;
      logic [1:0] d0;
      fill_stack(2);
      pops0 = pop_total; bus.out_ready = 1'b0; reverse = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      bound = 0;
      while (bus.out_valid !== 1'b1 && bound < 50) begin tick(); bound++; end
      tests++;
      if (bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL bp_valid_wait: valid %b after 50 cycles, need 1", bus.out_valid);
      end
      d0 = bus.out_dir;
      for (int i = 0; i < 10; i++) begin
         tick();
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_dir !== d0 || bus.stk_pop !== 1'b0) begin
            fails++;
            $display("FAIL bp_stall%0d: valid %b dir %b pop %b, need 1 %b 0", i, bus.out_valid, bus.out_dir, bus.stk_pop, d0);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      tests++;
      if (bus.stk_pop !== 1'b1 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_pop: pop %b valid %b, need 1 0", bus.stk_pop, bus.out_valid);
      end
      for (int i = 0; i < S + 2; i++) tick();
      tests++;
      if (pop_total - pops0 != 1 || bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL bp_single_pop: pops %0d valid %b, need 1 1", pop_total - pops0, bus.out_valid);
      end
      bus.out_ready = 1'b1;
      bound = 0;
      while (done !== 1'b1 && bound < 50) begin tick(); bound++; end
      tests++;
      if (done !== 1'b1 || count !== 9'd2 || pop_total - pops0 != 2) begin
         fails++;
         $display("FAIL bp_finish: done %b count %0d pops %0d, need 1 2 2", done, count, pop_total - pops0);
      end
      tick();
      $display("[TB] backpressure: 10-cycle stall, dir %b held, pops %0d", d0, pop_total - pops0);
   endtask

   task automatic test_abort();
      int pops0, bound;
      fill_stack(3);
      pops0 = pop_total; bus.out_ready = 1'b1; reverse = 1'($urandom); start = 1'b1;
      tick();
      start = 1'b0;
      bound = 0;
      while (bus.out_valid !== 1'b1 && bound < 50) begin tick(); bound++; end
      tick();
      bus.out_ready = 1'b0;
      bound = 0;
      while (bus.out_valid !== 1'b1 && bound < 50) begin tick(); bound++; end
      tests++;
      if (bus.out_valid !== 1'b1 || count !== 9'd1) begin
         fails++;
         $display("FAIL abort_setup: valid %b count %0d, need 1 1", bus.out_valid, count);
      end
      abort = 1'b1; bus.out_ready = 1'b1;
      tick();
      abort = 1'b0; bus.out_ready = 1'b0;
      tests++;
      if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.stk_pop !== 1'b0 || done !== 1'b0 || count !== 9'd1) begin
         fails++;
         $display("FAIL abort_idle: valid %b busy %b pop %b done %b count %0d, need 0 0 0 0 1",
                  bus.out_valid, busy, bus.stk_pop, done, count);
      end
      tick();
      tick();
      tests++;
      if (pop_total - pops0 != 1 || stk.size() != 2 || done !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_no_pop: pops %0d depth %0d done %b busy %b, need 1 2 0 0",
                  pop_total - pops0, stk.size(), done, busy);
      end
      $display("[TB] abort: cancelled with ready high, count %0d, %0d entries left", count, stk.size());
      test_drain("resume", 1'($urandom));
   endtask

   task automatic test_start_abort_idle();
      int pops0;
      fill_stack(2);
      pops0 = pop_total; bus.out_ready = 1'b1; start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < S + 4; i++) begin
         tick();
         tests++;
         if (busy !== 1'b0 || bus.out_valid !== 1'b0 || pop_total != pops0) begin
            fails++;
            $display("FAIL start_abort%0d: busy %b valid %b pops %0d, need 0 0 0", i, busy, bus.out_valid, pop_total - pops0);
         end
      end
      $display("[TB] start+abort in idle: stayed idle");
      stk.delete(); refresh_stack();
   endtask

   task automatic test_reset_mid_drain();
      int pops0, bound;
      fill_stack(2);
      pops0 = pop_total; bus.out_ready = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      bound = 0;
      while (bus.out_valid !== 1'b1 && bound < 50) begin tick(); bound++; end
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({busy, done, count, bus.stk_pop, bus.out_valid, bus.out_dir, bus.out_move} !== '0) begin
         fails++;
         $display("FAIL reset_async: busy %b done %b count %0d pop %b valid %b dir %b move %b, need all 0",
                  busy, done, count, bus.stk_pop, bus.out_valid, bus.out_dir, bus.out_move);
      end
      bus.out_ready = 1'b1;
      tick();
      rst = 1'b1;
      for (int i = 0; i < S + 4; i++) begin
         tick();
         tests++;
         if (done !== 1'b0 || bus.stk_pop !== 1'b0 || busy !== 1'b0 || pop_total != pops0) begin
            fails++;
            $display("FAIL reset_after%0d: done %b pop %b busy %b pops %0d, need 0 0 0 0",
                     i, done, bus.stk_pop, busy, pop_total - pops0);
         end
      end
      $display("[TB] reset mid-drain: outputs cleared, no pop or done after release");
      stk.delete(); refresh_stack();
   endtask

   task automatic test_random_drains();
      for (int r = 0; r < 6; r++) begin
         fill_stack(int'($urandom_range(0, 8)));
         test_drain("random", 1'($urandom));
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      refresh_stack();
      test_reset();
      stk.delete(); refresh_stack();
      test_drain("empty", 1'b0);
      test_fixed_stacks();
      test_backpressure();
      test_abort();
      test_start_abort_idle();
      test_reset_mid_drain();
      test_random_drains();
      tests++;
      if (pop_empty_err != 0) begin
         fails++;
         $display("FAIL pop_while_empty: %0d pops on empty stack, need 0", pop_empty_err);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
